// File: rtl/demux_1to8_32b_hs.sv
// Registered 1-to-8 demultiplexer with valid/ready handshake and broadcast.
// Each output channel owns a one-entry register so a stalled consumer only blocks its own channel.
module demux_1to8_32b_hs #(
  parameter int size = 32
) (
  input  logic            CGRA_Clock,
  input  logic            CGRA_Reset,
  input  logic [size-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      select,
  input  logic            bcast,
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic [size-1:0] out2,
  output logic [size-1:0] out3,
  output logic [size-1:0] out4,
  output logic [size-1:0] out5,
  output logic [size-1:0] out6,
  output logic [size-1:0] out7,
  output logic [7:0]      out_valid,
  input  logic [7:0]      out_ready
);

  logic [size-1:0] data_q [8];
  logic [7:0]      valid_q;
  logic [7:0]      free;
  logic [7:0]      load;
  logic            accept;

  // A broadcast waits until every channel is free in the same cycle, so it is never split.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load     = '0;
    free     = ~valid_q | out_ready;
    in_ready = bcast ? &free : free[select];
    accept   = in_valid & in_ready;
    if (accept) begin
      if (bcast) load = '1;
      else       load[select] = 1'b1;
    end
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      valid_q <= '0;
      // NOTE: the data registers are reset as well, so every out<i> reads 0 while reset is high.
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        // NOTE: non-blocking assignments keep all channel updates based on pre-edge values.
        if (load[i]) begin
          data_q[i]  <= in;
          valid_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out4      = data_q[4];
  assign out5      = data_q[5];
  assign out6      = data_q[6];
  assign out7      = data_q[7];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1to8_32b_hs.sv
// Directed and scoreboard-checked bench for demux_1to8_32b_hs.
// Inputs change just after the rising edge; outputs are compared 1 time unit later.
module tb_demux_1to8_32b_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  select;
  logic        bcast;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [31:0] outs [8];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sbq [8][$];

  always #5 clk = ~clk;

  assign outs[0] = out0; assign outs[1] = out1; assign outs[2] = out2; assign outs[3] = out3;
  assign outs[4] = out4; assign outs[5] = out5; assign outs[6] = out6; assign outs[7] = out7;

  demux_1to8_32b_hs #(.size(32)) dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .bcast(bcast),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = '0; in_valid = 1'b0; select = '0; bcast = 1'b0; out_ready = '0;
    #12;
    vectors++;
    if (out_valid !== 8'h00) begin
      miscompares++; $display("FAIL reset_init out_valid=%h required 00", out_valid);
    end
    rst = 1'b0;
    tick();
    select = 3'd2; in = 32'h2222_2222; in_valid = 1'b1;
    tick();
    select = 3'd5; in = 32'h5555_5555;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 8'h24) begin
      miscompares++; $display("FAIL reset_fill out_valid=%h required 24", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 8'h00 || out2 !== 32'h0 || out5 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async out_valid=%h out2=%h out5=%h required 00/0/0", out_valid, out2, out5);
    end
    #3 rst = 1'b0;
    out_ready = 8'hFF;
    bcast = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready in_ready=%b required 1", in_ready);
    end
    bcast = 1'b0;
    tick();
  endtask

  task automatic test_unicast();
    out_ready = 8'h00; select = 3'd3; in = 32'hDEAD_BEEF; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL uni_ready_empty in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 8'h08 || out3 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL uni_latency out_valid=%h out3=%h required 08/deadbeef", out_valid, out3);
    end
    in = 32'h1234_5678; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL uni_full in_ready=%b required 0", in_ready);
    end
    out_ready = 8'h08;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL uni_drain_ready in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 8'h08 || out3 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL uni_replace out_valid=%h out3=%h required 08/12345678", out_valid, out3);
    end
    tick();
    vectors++;
    if (out_valid !== 8'h00) begin
      miscompares++; $display("FAIL uni_empty out_valid=%h required 00", out_valid);
    end
  endtask

  task automatic test_streaming();
    select = 3'd6; out_ready = 8'h40; in_valid = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      in = 32'(w);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL stream_ready word %0d in_ready=%b required 1", w, in_ready);
      end
      tick();
      vectors++;
      if (out6 !== 32'(w) || out_valid !== 8'h40) begin
        miscompares++;
        $display("FAIL stream_out word %0d out6=%h out_valid=%h required %h/40", w, out6, out_valid, 32'(w));
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 8'h00) begin
      miscompares++; $display("FAIL stream_drain out_valid=%h required 00", out_valid);
    end
  endtask

  task automatic test_isolation();
    out_ready = 8'h00; select = 3'd0; in = 32'hC0C0_0000; in_valid = 1'b1;
    tick();
    select = 3'd1; in = 32'h0000_0011;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL iso_ready in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 8'h03 || out1 !== 32'h11 || out0 !== 32'hC0C0_0000) begin
      miscompares++;
      $display("FAIL iso_hold out_valid=%h out0=%h out1=%h required 03/c0c00000/11", out_valid, out0, out1);
    end
    out_ready = 8'hFF;
    tick();
    vectors++;
    if (out_valid !== 8'h00) begin
      miscompares++; $display("FAIL iso_drain out_valid=%h required 00", out_valid);
    end
  endtask

  task automatic test_broadcast_block();
    out_ready = 8'h00; select = 3'd7; in = 32'h0000_0077; in_valid = 1'b1;
    tick();
    bcast = 1'b1; in = 32'hA5A5_A5A5;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bc_blocked in_ready=%b required 0", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 8'h80 || out7 !== 32'h77 || out0 !== 32'hC0C0_0000 || out1 !== 32'h11) begin
      miscompares++;
      $display("FAIL bc_nochange out_valid=%h out7=%h out0=%h out1=%h required 80/77/c0c00000/11",
               out_valid, out7, out0, out1);
    end
    out_ready = 8'h80;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bc_release in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00;
    vectors++;
    if (out_valid !== 8'hFF) begin
      miscompares++; $display("FAIL bc_valid out_valid=%h required ff", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outs[i] !== 32'hA5A5_A5A5) begin
        miscompares++; $display("FAIL bc_data ch%0d out=%h required a5a5a5a5", i, outs[i]);
      end
    end
    out_ready = 8'hFF;
    tick();
  endtask

  // Drains retire the head word first, then an accepted word joins each target queue.
  task automatic sb_step(input logic [31:0] word_ok, output logic accepted);
    logic [7:0] exp_free;
    logic       exp_ready;
    for (int i = 0; i < 8; i++) exp_free[i] = (sbq[i].size() == 0) | out_ready[i];
    exp_ready = bcast ? &exp_free : exp_free[select];
    vectors++;
    if (in_ready !== exp_ready) begin
      miscompares++; $display("FAIL rnd_ready in_ready=%b required %b", in_ready, exp_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (sbq[i].size() != 0 && out_ready[i]) begin
        vectors++;
        if (outs[i] !== sbq[i][0]) begin
          miscompares++; $display("FAIL rnd_data ch%0d out=%h required %h", i, outs[i], sbq[i][0]);
        end
        void'(sbq[i].pop_front());
      end
    end
    accepted = in_valid & exp_ready;
    if (accepted) begin
      for (int i = 0; i < 8; i++)
        if (bcast || select == 3'(i)) sbq[i].push_back(word_ok);
    end
  endtask

  task automatic check_valid_mask();
    logic [7:0] exp_valid;
    for (int i = 0; i < 8; i++) exp_valid[i] = (sbq[i].size() != 0);
    vectors++;
    if (out_valid !== exp_valid) begin
      miscompares++; $display("FAIL rnd_valid out_valid=%h required %h", out_valid, exp_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] word;
    logic        hold;
    logic        acc;
    int          left;
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) sbq[i].delete();
    tick();
    word = 32'h1000_0000;
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        select   = 3'($urandom_range(0, 7));
        bcast    = ($urandom_range(0, 7) == 0);
        in       = word;
      end
      out_ready = 8'($urandom) | 8'($urandom);
      #1;
      sb_step(word, acc);
      if (acc) word = word + 1;
      hold = in_valid & ~acc;
      tick();
      check_valid_mask();
    end
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'hFF;
    #1;
    sb_step(word, acc);
    tick();
    check_valid_mask();
    left = 0;
    for (int i = 0; i < 8; i++) left += sbq[i].size();
    vectors++;
    if (left != 0) begin
      miscompares++; $display("FAIL rnd_leftover words=%0d required 0", left);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_streaming();
    test_isolation();
    test_broadcast_block();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
